// File: rtl/ex_mem_pipe_pkg.sv
// ============================================================================
// Module : ex_mem_pipe_pkg
// Brief  : Shared widths, bubble constant and EX/MEM control-field layout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_mem_pipe_pkg;

    localparam int DATA_WIDTH     = 16;
    localparam int REG_ADDR_WIDTH = 3;

    // Control-word bit positions, shared by the ID/EX, EX/MEM and MEM/WB stages
    localparam int CTL_VALID  = 0;
    localparam int CTL_REG_WR = 1;
    localparam int CTL_MEM_RD = 2;
    localparam int CTL_MEM_WR = 3;
    localparam int CTL_HALT   = 4;
    localparam int CTL_ERR    = 5;
    localparam int CTL_WIDTH  = 6;

    localparam logic [CTL_WIDTH-1:0] CTL_BUBBLE = '0;

endpackage

`default_nettype wire

// File: rtl/ex_mem_pipe_reg_en.sv
// ============================================================================
// Module : ex_mem_pipe_reg_en
// Brief  : Parameterized register with enable and synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe_reg_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear outranks enable so reset and bubbles land even while holding
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe.sv
// ============================================================================
// Module : ex_mem_pipe
// Brief  : EX/MEM pipeline register with stall, flush, sticky halt,
//          forwarding source, load-use detect and retired-instruction count.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_pipe #(
    parameter int DATA_WIDTH     = ex_mem_pipe_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = ex_mem_pipe_pkg::REG_ADDR_WIDTH,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_alu_out,
    input  logic                      ex_zero,
    input  logic                      ex_ofl,
    input  logic [DATA_WIDTH-1:0]     ex_store_data,
    input  logic [DATA_WIDTH-1:0]     ex_pc_plus2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wr_reg,
    input  logic                      ex_reg_wr_en,
    input  logic                      ex_mem_rd,
    input  logic                      ex_mem_wr,
    input  logic                      ex_halt,
    input  logic                      ex_err,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_rs_used,
    input  logic                      id_rt_used,
    output logic                      mem_valid,
    output logic [DATA_WIDTH-1:0]     mem_alu_out,
    output logic [DATA_WIDTH-1:0]     mem_store_data,
    output logic [DATA_WIDTH-1:0]     mem_pc_plus2,
    output logic                      mem_zero,
    output logic                      mem_ofl,
    output logic [REG_ADDR_WIDTH-1:0] mem_wr_reg,
    output logic                      mem_reg_wr_en,
    output logic                      mem_mem_rd,
    output logic                      mem_mem_wr,
    output logic                      mem_halt,
    output logic                      mem_err,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_reg,
    output logic                      load_use,
    output logic                      halted,
    output logic [CNT_WIDTH-1:0]      insn_cnt
);

    import ex_mem_pipe_pkg::*;

    logic                      r_halted;
    logic [CNT_WIDTH-1:0]      r_insn_cnt;
    logic                      w_load;
    logic                      w_bubble;
    logic                      w_en;
    logic                      w_clr;
    logic [CTL_WIDTH-1:0]      w_ctl_d;
    logic [CTL_WIDTH-1:0]      w_ctl_q;
    logic [1:0]                w_flags_q;
    logic [3*DATA_WIDTH-1:0]   w_data_q;

    // Priority rst > flush > stall > halted > normal load
    assign w_load   = ~flush & ~stall & ~r_halted & ex_valid;
    assign w_bubble = ~stall & (r_halted | ~ex_valid);
    assign w_en     = ~stall | flush;
    assign w_clr    = rst | flush | w_bubble;

    always_comb begin
        w_ctl_d             = CTL_BUBBLE;
        w_ctl_d[CTL_VALID]  = ex_valid;
        w_ctl_d[CTL_REG_WR] = ex_valid & ex_reg_wr_en;
        w_ctl_d[CTL_MEM_RD] = ex_valid & ex_mem_rd;
        w_ctl_d[CTL_MEM_WR] = ex_valid & ex_mem_wr;
        w_ctl_d[CTL_HALT]   = ex_valid & ex_halt;
        w_ctl_d[CTL_ERR]    = ex_valid & ex_err;
    end

    ex_mem_pipe_reg_en #(.WIDTH(CTL_WIDTH)) u_ctl_reg (
        .clk (clk),
        .en  (w_en),
        .clr (w_clr),
        .d   (w_ctl_d),
        .q   (w_ctl_q)
    );

    ex_mem_pipe_reg_en #(.WIDTH(2)) u_flags_reg (
        .clk (clk),
        .en  (w_en),
        .clr (w_clr),
        .d   ({ex_zero, ex_ofl}),
        .q   (w_flags_q)
    );

    ex_mem_pipe_reg_en #(.WIDTH(3*DATA_WIDTH)) u_data_reg (
        .clk (clk),
        .en  (w_en),
        .clr (w_clr),
        .d   ({ex_alu_out, ex_store_data, ex_pc_plus2}),
        .q   (w_data_q)
    );

    ex_mem_pipe_reg_en #(.WIDTH(REG_ADDR_WIDTH)) u_wr_reg (
        .clk (clk),
        .en  (w_en),
        .clr (w_clr),
        .d   (ex_wr_reg),
        .q   (mem_wr_reg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted   <= 1'b0;
            r_insn_cnt <= '0;
        end else if (w_load) begin
            r_insn_cnt <= r_insn_cnt + CNT_WIDTH'(1);
            if (ex_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign mem_valid      = w_ctl_q[CTL_VALID];
    assign mem_reg_wr_en  = w_ctl_q[CTL_REG_WR];
    assign mem_mem_rd     = w_ctl_q[CTL_MEM_RD];
    assign mem_mem_wr     = w_ctl_q[CTL_MEM_WR];
    assign mem_halt       = w_ctl_q[CTL_HALT];
    assign mem_err        = w_ctl_q[CTL_ERR];
    assign mem_zero       = w_flags_q[1];
    assign mem_ofl        = w_flags_q[0];
    assign mem_alu_out    = w_data_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign mem_store_data = w_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign mem_pc_plus2   = w_data_q[DATA_WIDTH-1:0];
    assign halted         = r_halted;
    assign insn_cnt       = r_insn_cnt;

    // Load results are not ready until the end of MEM, so they cannot forward
    assign fwd_valid = mem_valid & mem_reg_wr_en & ~mem_mem_rd;
    assign fwd_reg   = mem_wr_reg;
    assign load_use  = mem_valid & mem_mem_rd & mem_reg_wr_en &
                       ((id_rs_used & (id_rs == mem_wr_reg)) |
                        (id_rt_used & (id_rt == mem_wr_reg)));

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
// ============================================================================
// Module : tb_ex_mem_pipe
// Brief  : Self-checking bench: vector table plus hand-written corner cases.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_pipe;

    logic        clk, rst;
    logic        ex_valid, ex_zero, ex_ofl, ex_reg_wr_en, ex_mem_rd, ex_mem_wr, ex_halt, ex_err;
    logic [15:0] ex_alu_out, ex_store_data, ex_pc_plus2;
    logic [2:0]  ex_wr_reg, id_rs, id_rt, mem_wr_reg, fwd_reg;
    logic        stall, flush, id_rs_used, id_rt_used;
    logic        mem_valid, mem_zero, mem_ofl, mem_reg_wr_en, mem_mem_rd, mem_mem_wr;
    logic        mem_halt, mem_err, fwd_valid, load_use, halted;
    logic [15:0] mem_alu_out, mem_store_data, mem_pc_plus2, insn_cnt;

    int n_pass  = 0;
    int n_total = 0;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_zero(ex_zero), .ex_ofl(ex_ofl), .ex_store_data(ex_store_data),
        .ex_pc_plus2(ex_pc_plus2), .ex_wr_reg(ex_wr_reg), .ex_reg_wr_en(ex_reg_wr_en),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_halt(ex_halt), .ex_err(ex_err),
        .stall(stall), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .mem_valid(mem_valid),
        .mem_alu_out(mem_alu_out), .mem_store_data(mem_store_data),
        .mem_pc_plus2(mem_pc_plus2), .mem_zero(mem_zero), .mem_ofl(mem_ofl),
        .mem_wr_reg(mem_wr_reg), .mem_reg_wr_en(mem_reg_wr_en), .mem_mem_rd(mem_mem_rd),
        .mem_mem_wr(mem_mem_wr), .mem_halt(mem_halt), .mem_err(mem_err),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .load_use(load_use),
        .halted(halted), .insn_cnt(insn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, irw, ird, iwm, ihalt, ierr, izero, iofl, stall, flush;
        logic [2:0]  iwr;
        logic [15:0] ialu, ist, ipc;
        logic        ev, erw, erd, ewm, ehalt, eerr, ezero, eofl, efwd;
        logic [2:0]  ewr;
        logic [15:0] ealu, est, epc, ecnt;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [75:0] pack_act();
        return {mem_valid, mem_reg_wr_en, mem_mem_rd, mem_mem_wr, mem_halt, mem_err,
                mem_zero, mem_ofl, mem_wr_reg, mem_alu_out, mem_store_data,
                mem_pc_plus2, fwd_valid, insn_cnt};
    endfunction

    function automatic logic [75:0] pack_exp(input vec_t v);
        return {v.ev, v.erw, v.erd, v.ewm, v.ehalt, v.eerr, v.ezero, v.eofl, v.ewr,
                v.ealu, v.est, v.epc, v.efwd, v.ecnt};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        ex_valid = v.iv; ex_reg_wr_en = v.irw; ex_mem_rd = v.ird; ex_mem_wr = v.iwm;
        ex_halt = v.ihalt; ex_err = v.ierr; ex_zero = v.izero; ex_ofl = v.iofl;
        stall = v.stall; flush = v.flush; ex_wr_reg = v.iwr;
        ex_alu_out = v.ialu; ex_store_data = v.ist; ex_pc_plus2 = v.ipc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vec_t z;
        z = '{default: '0};
        drive(z);
    endtask

    initial begin
        vec_t hold;
        rst = 1'b1;
        id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        idle();

        // Vector table: one pipeline edge per entry, expected state after the edge
        vecs[0] = '{iv:1, ialu:16'h1234, ist:16'hAAAA, ipc:16'h0002, iwr:5, irw:1,
                    ev:1, ealu:16'h1234, est:16'hAAAA, epc:16'h0002, ewr:5, erw:1,
                    efwd:1, ecnt:16'd1, default:'0};
        vecs[1] = '{iv:1, ialu:16'hBEEF, ist:16'h00BB, ipc:16'h0004, iwr:2, irw:1,
                    izero:1, iofl:1, ierr:1,
                    ev:1, ealu:16'hBEEF, est:16'h00BB, epc:16'h0004, ewr:2, erw:1,
                    eerr:1, ezero:1, eofl:1, efwd:1, ecnt:16'd2, default:'0};
        hold = vecs[1];
        hold.stall = 1; hold.iwr = 6; hold.izero = 0; hold.iofl = 0; hold.ierr = 0;
        hold.ialu = 16'h1111; vecs[2] = hold;
        hold.ialu = 16'h2222; vecs[3] = hold;
        hold.ialu = 16'h3333; vecs[4] = hold;
        vecs[5] = '{stall:1, flush:1, iv:1, ialu:16'h4444, iwr:6, irw:1, ird:1,
                    ecnt:16'd2, default:'0};
        vecs[6] = '{iv:0, ialu:16'h5555, iwr:7, irw:1, iwm:1, izero:1,
                    ecnt:16'd2, default:'0};
        vecs[7] = '{iv:1, ialu:16'h0040, ist:16'h1357, ipc:16'h0010, iwr:1, iwm:1,
                    ev:1, ealu:16'h0040, est:16'h1357, epc:16'h0010, ewr:1, ewm:1,
                    efwd:0, ecnt:16'd3, default:'0};
        vecs[8] = '{iv:1, ialu:16'h0080, iwr:3, irw:1, ird:1,
                    ev:1, ealu:16'h0080, ewr:3, erw:1, erd:1, efwd:0,
                    ecnt:16'd4, default:'0};
        vecs[9] = '{flush:1, iv:1, ialu:16'h9999, iwr:4, irw:1, ecnt:16'd4, default:'0};

        repeat (2) tick();
        check("reset_state", {4'b0, pack_act()}, 80'd0);
        check("reset_flags", {77'd0, fwd_reg, halted, load_use}, 80'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            tick();
            check($sformatf("vec%0d", i), {4'b0, pack_act()}, {4'b0, pack_exp(vecs[i])});
        end

        // Load-use detection against a load to r3
        vecs[0] = '{iv:1, ialu:16'h0100, iwr:3, irw:1, ird:1, default:'0};
        drive(vecs[0]);
        tick();
        idle();
        stall = 1'b1;
        id_rt = 3'd3; id_rt_used = 1'b1; #1;
        check("lu_rt_hit", {77'd0, load_use, fwd_valid, mem_valid}, {77'd0, 3'b101});
        check("lu_fwd_reg", {77'd0, fwd_reg}, 80'd3);
        id_rt = 3'd4; #1;
        check("lu_rt_miss", {79'd0, load_use}, 80'd0);
        id_rs = 3'd3; #1;
        check("lu_rs_unused", {79'd0, load_use}, 80'd0);
        id_rs_used = 1'b1; #1;
        check("lu_rs_hit", {79'd0, load_use}, 80'd1);
        id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        stall = 1'b0;

        // Sticky halt: counter is 5 after the load above
        vecs[0] = '{iv:1, ihalt:1, ialu:16'h00AA, iwr:1, default:'0};
        drive(vecs[0]);
        tick();
        check("halt_enter", {61'd0, mem_valid, mem_halt, halted, insn_cnt}, {61'd0, 3'b111, 16'd6});
        vecs[0] = '{iv:1, ialu:16'h7777, iwr:2, irw:1, default:'0};
        drive(vecs[0]);
        tick();
        check("halt_bubble", {4'b0, pack_act()}, {60'd0, 16'd6});
        tick();
        check("halt_sticky", {79'd0, halted}, 80'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("halt_rst", {63'd0, halted, insn_cnt}, 80'd0);

        // Reset while stalled on valid data
        drive(vecs[0]);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        check("rst_mid_stall", {3'b0, halted, pack_act()}, 80'd0);

        // Counter wrap
        idle();
        ex_valid = 1'b1;
        repeat (65535) tick();
        check("cnt_ffff", {64'd0, insn_cnt}, {64'd0, 16'hFFFF});
        ex_valid = 1'b0;
        tick();
        check("cnt_bubble", {63'd0, mem_valid, insn_cnt}, {63'd0, 1'b0, 16'hFFFF});
        ex_valid = 1'b1; flush = 1'b1;
        tick();
        check("cnt_flush", {63'd0, mem_valid, insn_cnt}, {63'd0, 1'b0, 16'hFFFF});
        flush = 1'b0;
        tick();
        check("cnt_wrap", {63'd0, mem_valid, insn_cnt}, {63'd0, 1'b1, 16'h0000});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
